// File: rtl/acondicionador_botones.sv
// Three-channel push-button conditioner: polarity fix, 2-flop synchroniser,
// debounce and long-hold detection, producing registered level and pulses.
module acondicionador_botones #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 250_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn_raw,
  output logic [2:0] btn_level,
  output logic [2:0] btn_press,
  output logic [2:0] btn_release,
  output logic [2:0] btn_hold
);

  localparam int unsigned N_CH   = 3;
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    HELD,
    DEB_RELEASE
  } state_t;

  logic [N_CH-1:0] pol;
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;

  assign pol = ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Two-flop synchroniser; reset value is the logical "not pressed" level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pol;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t              state, state_nxt;
    logic [DEB_W-1:0]    deb_cnt, deb_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                from_held, from_held_nxt;
    logic                active;
    logic                level_q, press_q, rel_q, hold_q;
    logic                level_nxt, press_nxt, rel_nxt, hold_pulse_nxt;

    assign active = sync2[i];

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state     <= IDLE;
        deb_cnt   <= '0;
        hold_cnt  <= '0;
        from_held <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        rel_q     <= 1'b0;
        hold_q    <= 1'b0;
      end else begin
        state     <= state_nxt;
        deb_cnt   <= deb_nxt;
        hold_cnt  <= hold_nxt;
        from_held <= from_held_nxt;
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        rel_q     <= rel_nxt;
        hold_q    <= hold_pulse_nxt;
      end
    end

    // Next-state and pulse decode; glitches back to the origin freeze hold_cnt.
    always_comb begin
      state_nxt      = state;
      deb_nxt        = deb_cnt;
      hold_nxt       = hold_cnt;
      from_held_nxt  = from_held;
      press_nxt      = 1'b0;
      rel_nxt        = 1'b0;
      hold_pulse_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (active) begin
            state_nxt = DEB_PRESS;
            deb_nxt   = '0;
          end
        end
        DEB_PRESS: begin
          if (!active) begin
            state_nxt = IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state_nxt = PRESSED;
            hold_nxt  = '0;
            press_nxt = 1'b1;
          end else begin
            deb_nxt = deb_cnt + DEB_W'(1);
          end
        end
        PRESSED: begin
          if (!active) begin
            state_nxt     = DEB_RELEASE;
            deb_nxt       = '0;
            from_held_nxt = 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_nxt      = HELD;
            hold_pulse_nxt = 1'b1;
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        HELD: begin
          if (!active) begin
            state_nxt     = DEB_RELEASE;
            deb_nxt       = '0;
            from_held_nxt = 1'b1;
          end
        end
        DEB_RELEASE: begin
          if (active) begin
            state_nxt = from_held ? HELD : PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state_nxt = IDLE;
            rel_nxt   = 1'b1;
          end else begin
            deb_nxt = deb_cnt + DEB_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
      level_nxt = (state_nxt == PRESSED) || (state_nxt == HELD) ||
                  (state_nxt == DEB_RELEASE);
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
    assign btn_hold[i]    = hold_q;
  end

endmodule

// File: tb/tb_acondicionador_botones.sv
// Scoreboard bench for acondicionador_botones (DEBOUNCE=4, HOLD=10, active-low).
module tb_acondicionador_botones;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] btn_raw = 3'b111;
  logic [2:0] btn_level, btn_press, btn_release, btn_hold;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  press;
    logic [2:0]  rel;
    logic [2:0]  hold;
    logic [2:0]  level;
  } ev_t;

  ev_t q[$];

  acondicionador_botones #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_hold(btn_hold)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [2:0] p, input logic [2:0] r,
                      input logic [2:0] h, input logic [2:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.hold = h; e.level = l;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle with any pulse must match the next expected event.
  always @(negedge clk) begin
    if ((btn_press | btn_release | btn_hold) != 3'b000) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'({btn_press, btn_release, btn_hold}), 32'h0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("press", 32'(btn_press), 32'(e.press));
        chk("release", 32'(btn_release), 32'(e.rel));
        chk("hold", 32'(btn_hold), 32'(e.hold));
        chk("level", 32'(btn_level), 32'(e.level));
      end
    end
  end

  initial begin
    int unsigned e0;

    // Reset with all buttons pressed: outputs clear immediately.
    #1 reset = 1'b1;
    btn_raw = 3'b000;
    #1;
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_press", 32'(btn_press), 32'h0);
    chk("rst_release", 32'(btn_release), 32'h0);
    chk("rst_hold", 32'(btn_hold), 32'h0);
    wait_cyc(3);
    chk("rst_level_clocked", 32'(btn_level), 32'h0);
    btn_raw = 3'b111;
    reset = 1'b0;
    wait_cyc(50);
    chk("quiet_level", 32'(btn_level), 32'h0);

    // Channel 1 low for 30 cycles: press E6, hold E16, release R0+6 = E36.
    e0 = cyc + 1;
    btn_raw[1] = 1'b0;
    push(e0 + 6,  3'b010, 3'b000, 3'b000, 3'b010);
    push(e0 + 16, 3'b000, 3'b000, 3'b010, 3'b010);
    push(e0 + 36, 3'b000, 3'b010, 3'b000, 3'b000);
    wait_cyc(30);
    btn_raw[1] = 1'b1;
    wait_cyc(15);

    // Channel 2 bounce of 3 cycles: no response.
    btn_raw[2] = 1'b0;
    wait_cyc(3);
    btn_raw[2] = 1'b1;
    wait_cyc(10);
    chk("bounce_level", 32'(btn_level), 32'h0);

    // Channel 2 low 5 cycles: press E6, release at R0+6 = E11, no hold.
    e0 = cyc + 1;
    btn_raw[2] = 1'b0;
    push(e0 + 6,  3'b100, 3'b000, 3'b000, 3'b100);
    push(e0 + 11, 3'b000, 3'b100, 3'b000, 3'b000);
    wait_cyc(5);
    btn_raw[2] = 1'b1;
    wait_cyc(15);

    // Channel 1 glitch in PRESSED: raw high at E10,E11, FSM sees it at E12,E13
    // (hold_cnt frozen at 5), returns at E14; three non-advancing edges move
    // the hold from E16 to E19. Release at E30+6.
    e0 = cyc + 1;
    btn_raw[1] = 1'b0;
    push(e0 + 6,  3'b010, 3'b000, 3'b000, 3'b010);
    push(e0 + 19, 3'b000, 3'b000, 3'b010, 3'b010);
    push(e0 + 36, 3'b000, 3'b010, 3'b000, 3'b000);
    wait_cyc(10);
    btn_raw[1] = 1'b1;
    wait_cyc(2);
    btn_raw[1] = 1'b0;
    chk("glitch_level", 32'(btn_level), 32'h2);
    wait_cyc(18);
    btn_raw[1] = 1'b1;
    wait_cyc(20);

    // All three simultaneously for 20 cycles.
    e0 = cyc + 1;
    btn_raw = 3'b000;
    push(e0 + 6,  3'b111, 3'b000, 3'b000, 3'b111);
    push(e0 + 16, 3'b000, 3'b000, 3'b111, 3'b111);
    push(e0 + 26, 3'b000, 3'b111, 3'b000, 3'b000);
    wait_cyc(20);
    btn_raw = 3'b111;
    wait_cyc(15);

    // Channel 0 into HELD, then a one-cycle reset with the button still low.
    e0 = cyc + 1;
    btn_raw[0] = 1'b0;
    push(e0 + 6,  3'b001, 3'b000, 3'b000, 3'b001);
    push(e0 + 16, 3'b000, 3'b000, 3'b001, 3'b001);
    wait_cyc(20);
    chk("held_level", 32'(btn_level), 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_level", 32'(btn_level), 32'h0);
    chk("midrst_pulses", 32'({btn_press, btn_release, btn_hold}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    e0 = cyc + 1;
    push(e0 + 6,  3'b001, 3'b000, 3'b000, 3'b001);
    push(e0 + 14, 3'b000, 3'b001, 3'b000, 3'b000);
    wait_cyc(8);
    btn_raw[0] = 1'b1;
    wait_cyc(20);

    chk("events_outstanding", 32'(q.size()), 32'h0);
    chk("final_level", 32'(btn_level), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
